// File: rtl/counter_pkg.sv
// Shared constants, direction encoding and load clamping for enable_counter.
package counter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Values above the configured ceiling load as the ceiling itself.
  function automatic logic [31:0] clamp_load(input logic [31:0] value,
                                             input logic [31:0] max_count);
    return (value > max_count) ? max_count : value;
  endfunction

endpackage

// File: rtl/counter_next.sv
// Combinational next-count and terminal-count logic for enable_counter.
// COUNTER_SAT_EN selects saturation at the boundaries instead of wrap-around.
module counter_next
  import counter_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}}
) (
  input  logic [WIDTH-1:0] i_cur,
  input  logic             i_enable,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_down,
  output logic [WIDTH-1:0] o_next,
  output logic             o_terminal_count
);

  dir_e             w_dir;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_at_boundary;
  logic [WIDTH-1:0] w_load_clamped;
  logic [WIDTH-1:0] w_up_next;
  logic [WIDTH-1:0] w_down_next;

  assign w_dir          = dir_e'(i_down);
  assign w_at_max       = (i_cur == MAX_COUNT);
  assign w_at_zero      = (i_cur == '0);
  assign w_at_boundary  = (w_dir == DIR_DOWN) ? w_at_zero : w_at_max;
  assign w_load_clamped = WIDTH'(clamp_load(32'(i_load_value), 32'(MAX_COUNT)));

  // Boundaries are compared explicitly so a MAX_COUNT below 2**WIDTH-1 still wraps.
`ifdef COUNTER_SAT_EN
  assign w_up_next   = w_at_max  ? MAX_COUNT : i_cur + 1'b1;
  assign w_down_next = w_at_zero ? '0        : i_cur - 1'b1;
`else
  assign w_up_next   = w_at_max  ? '0        : i_cur + 1'b1;
  assign w_down_next = w_at_zero ? MAX_COUNT : i_cur - 1'b1;
`endif

  assign o_terminal_count = i_enable & ~i_load & w_at_boundary;

  always_comb begin
    o_next = i_cur;
    if (i_load) begin
      o_next = w_load_clamped;
    end else if (i_enable) begin
      o_next = (w_dir == DIR_DOWN) ? w_down_next : w_up_next;
    end
  end

endmodule

// File: rtl/enable_counter.sv
// Up/down counter with enable, parallel load and terminal-count flag.
// Define COUNTER_SAT_EN for saturating instead of wrapping at the boundaries.
module enable_counter
  import counter_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] MAX_COUNT   = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] counter_out,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             down,
  output logic             terminal_count
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next;

  counter_next #(
    .WIDTH    (WIDTH),
    .MAX_COUNT(MAX_COUNT)
  ) u_next (
    .i_cur           (r_count),
    .i_enable        (enable),
    .i_load          (load),
    .i_load_value    (load_value),
    .i_down          (down),
    .o_next          (w_next),
    .o_terminal_count(terminal_count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= RESET_VALUE;
    end else begin
      r_count <= w_next;
    end
  end

  assign counter_out = r_count;

endmodule

// File: tb/tb_enable_counter.sv
// Bench for enable_counter: a default 4-bit instance and an 8-bit instance
// limited to MAX_COUNT=9, driven with directed vectors and checked by a queue.
module tb_enable_counter;

`ifdef COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clock;
  logic       reset;

  logic       en4, load4, down4, tc4;
  logic [3:0] lv4, cnt4;
  logic       en9, load9, down9, tc9;
  logic [7:0] lv9, cnt9;

  int total = 0;
  int bad   = 0;

  // {sel, exp_tc, exp_count[7:0]}; sel=1 addresses the MAX_COUNT=9 instance
  logic [9:0] exp_q[$];

  enable_counter dut4 (
    .clock         (clock),
    .reset         (reset),
    .enable        (en4),
    .counter_out   (cnt4),
    .load          (load4),
    .load_value    (lv4),
    .down          (down4),
    .terminal_count(tc4)
  );

  enable_counter #(
    .WIDTH      (8),
    .MAX_COUNT  (8'd9),
    .RESET_VALUE(8'd0)
  ) dut9 (
    .clock         (clock),
    .reset         (reset),
    .enable        (en9),
    .counter_out   (cnt9),
    .load          (load9),
    .load_value    (lv9),
    .down          (down9),
    .terminal_count(tc9)
  );

  // ---------------- clock ----------------
  initial begin
    clock = 1'b1;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (%b) expected %0d (%b) at t=%0t", name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive4(input logic en, input logic ld, input logic [3:0] lv, input logic dn,
                        input logic [3:0] exp_cnt, input logic exp_tc);
    @(negedge clock);
    en4 = en; load4 = ld; lv4 = lv; down4 = dn;
    exp_q.push_back({1'b0, exp_tc, 4'h0, exp_cnt});
  endtask

  task automatic drive9(input logic en, input logic ld, input logic [7:0] lv, input logic dn,
                        input logic [7:0] exp_cnt, input logic exp_tc);
    @(negedge clock);
    en9 = en; load9 = ld; lv9 = lv; down9 = dn;
    exp_q.push_back({1'b1, exp_tc, exp_cnt});
  endtask

  // ---------------- monitor ----------------
  // terminal_count is sampled while the vector is applied, the count after the edge.
  initial begin
    logic       tc_s;
    logic [9:0] e;
    forever begin
      @(negedge clock);
      #2;
      if (exp_q.size() > 0) begin
        tc_s = exp_q[0][9] ? tc9 : tc4;
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        if (e[9]) begin
          check("cnt9", cnt9, e[7:0]);
          check("tc9", {7'd0, tc_s}, {7'd0, e[8]});
        end else begin
          check("cnt4", {4'd0, cnt4}, e[7:0]);
          check("tc4", {7'd0, tc_s}, {7'd0, e[8]});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] nxt;
    reset = 1'b0;
    en4 = 0; load4 = 0; lv4 = '0; down4 = 0;
    en9 = 0; load9 = 0; lv9 = '0; down9 = 0;

    // asynchronous reset with no clock edge in between
    #5 reset = 1'b1;
    #1 check("reset_async4", {4'd0, cnt4}, 8'd0);
    check("reset_async9", cnt9, 8'd0);
    #6 check("reset_held", {4'd0, cnt4}, 8'd0);
    #3 reset = 1'b0;

    // hold, then ten increments, then hold again
    drive4(0, 0, 4'd0, 0, 4'd0, 0);
    for (int i = 1; i <= 10; i++) drive4(1, 0, 4'd0, 0, 4'(i), 0);
    drive4(0, 0, 4'd0, 0, 4'd10, 0);
    drive4(0, 0, 4'd0, 0, 4'd10, 0);

    // full pass from 0; tc only while sitting at 1111
    drive4(1, 1, 4'd0, 0, 4'd0, 0);
    for (int i = 0; i < 16; i++) begin
      nxt = (i == 15) ? (SAT ? 4'd15 : 4'd0) : 4'(i + 1);
      drive4(1, 0, 4'd0, 0, nxt, (i == 15));
    end
    drive4(1, 0, 4'd0, 0, SAT ? 4'd15 : 4'd1, SAT);

    // down-count boundary at zero, then load overriding enable
    drive4(1, 1, 4'd0, 1, 4'd0, 0);
    drive4(1, 0, 4'd0, 1, SAT ? 4'd0 : 4'd15, 1);
    drive4(1, 0, 4'd0, 1, SAT ? 4'd0 : 4'd14, SAT);
    drive4(1, 1, 4'd5, 0, 4'd5, 0);
    drive4(1, 1, 4'd15, 0, 4'd15, 0);
    drive4(1, 0, 4'd0, 0, SAT ? 4'd15 : 4'd0, 1);
    drive4(0, 1, 4'd0, 1, 4'd0, 0);
    drive4(0, 0, 4'd0, 1, 4'd0, 0);

    // reach 0111 then reset between edges
    drive4(1, 1, 4'd6, 0, 4'd6, 0);
    drive4(1, 0, 4'd0, 0, 4'd7, 0);
    @(posedge clock);
    #3 reset = 1'b1;
    #1 check("reset_midcount", {4'd0, cnt4}, 8'd0);
    reset = 1'b0;
    drive4(1, 0, 4'd0, 0, 4'd1, 0);
    drive4(0, 0, 4'd0, 0, 4'd1, 0);

    // MAX_COUNT=9 instance: wrap at 9, clamp on load, down wrap to 9
    for (int i = 1; i <= 9; i++) drive9(1, 0, 8'd0, 0, 8'(i), 0);
    drive9(1, 0, 8'd0, 0, SAT ? 8'd9 : 8'd0, 1);
    drive9(1, 1, 8'd200, 0, 8'd9, 0);
    drive9(1, 0, 8'd0, 1, 8'd8, 0);
    drive9(0, 1, 8'd255, 1, 8'd9, 0);
    drive9(1, 1, 8'd0, 1, 8'd0, 0);
    drive9(1, 0, 8'd0, 1, SAT ? 8'd0 : 8'd9, 1);
    drive9(0, 0, 8'd0, 0, SAT ? 8'd0 : 8'd9, 0);

    // drain with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
    #2;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
